// File: rtl/boss_ctrl.sv
// Boss enemy behaviour sequencer: position, HP, attack phase and hit handling.
// Optional feature: define BOSS_ENRAGE_EN to enable the low-HP enrage mode.
module boss_ctrl #(
  parameter int unsigned START_X         = 600,
  parameter int unsigned GROUND_Y        = 450,
  parameter int unsigned X_MIN           = 106,
  parameter int unsigned X_MAX           = 694,
  parameter int unsigned SPEED           = 2,
  parameter int unsigned ATTACK_RANGE    = 120,
  parameter int unsigned WINDUP_FRAMES   = 30,
  parameter int unsigned JUMP_V0         = 12,
  parameter int unsigned GRAVITY         = 1,
  parameter int unsigned COOLDOWN_FRAMES = 60,
  parameter int unsigned HP_MAX          = 100,
  parameter int unsigned IFRAMES         = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_active,
  input  logic        frame_tick,
  input  logic [11:0] player_x,
  input  logic        hit_req,
  input  logic [6:0]  hit_dmg,
  output logic [11:0] boss_x,
  output logic [11:0] boss_y,
  output logic [6:0]  boss_hp,
  output logic        attack_active,
  output logic        boss_dead,
  output logic        enraged
);

  typedef enum logic [2:0] {StIdle, StChase, StWindup, StJump, StCooldown, StDead} state_e;

  state_e             state_q, state_d;
  logic [11:0]        x_q, x_d;
  logic signed [12:0] y_q, y_d;
  logic signed [7:0]  vy_q, vy_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [6:0]         hp_q, hp_d;
  logic [4:0]         iframe_q, iframe_d;
  logic               attack_q, attack_d;
  logic               dead_q, dead_d;
  logic               enraged_q, enraged_d;

  logic [11:0]        step;
  logic [6:0]         cd_last;
  logic [12:0]        x_raw;
  logic [11:0]        x_move;
  logic [11:0]        dist_after;
  logic signed [12:0] y_next;
  logic               hit_ok;

`ifdef BOSS_ENRAGE_EN
  assign step    = enraged_q ? 12'(2 * SPEED) : 12'(SPEED);
  assign cd_last = enraged_q ? 7'(COOLDOWN_FRAMES / 2 - 1) : 7'(COOLDOWN_FRAMES - 1);
`else
  assign step    = 12'(SPEED);
  assign cd_last = 7'(COOLDOWN_FRAMES - 1);
`endif

  // Horizontal pursuit step without overshoot, then clamp to the arena.
  always_comb begin
    x_raw = {1'b0, x_q};
    if (player_x > x_q) begin
      x_raw = (player_x - x_q < step) ? {1'b0, player_x} : {1'b0, x_q} + {1'b0, step};
    end else if (player_x < x_q) begin
      x_raw = (x_q - player_x < step) ? {1'b0, player_x} : {1'b0, x_q} - {1'b0, step};
    end
    if (x_raw < 13'(X_MIN)) begin
      x_move = 12'(X_MIN);
    end else if (x_raw > 13'(X_MAX)) begin
      x_move = 12'(X_MAX);
    end else begin
      x_move = x_raw[11:0];
    end
    dist_after = (player_x > x_move) ? player_x - x_move : x_move - player_x;
  end

  assign y_next = y_q + {{5{vy_q[7]}}, vy_q};
  assign hit_ok = hit_req && (iframe_q == '0) && (hp_q != '0) && (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    cnt_d    = cnt_q;
    hp_d     = hp_q;
    iframe_d = iframe_q;

    if (hit_ok) begin
      hp_d     = (hit_dmg >= hp_q) ? '0 : hp_q - hit_dmg;
      iframe_d = 5'(IFRAMES);
    end else if (frame_tick && (iframe_q != '0)) begin
      iframe_d = iframe_q - 5'd1;
    end

    if ((hp_q == '0) && (state_q != StIdle)) begin
      state_d = StDead;
    end else if (frame_tick) begin
      unique case (state_q)
        StIdle: state_d = StChase;
        StChase: begin
          x_d = x_move;
          if (dist_after <= 12'(ATTACK_RANGE)) begin
            state_d = StWindup;
            cnt_d   = '0;
          end
        end
        StWindup: begin
          if (cnt_q >= 7'(WINDUP_FRAMES - 1)) begin
            state_d = StJump;
            cnt_d   = '0;
            vy_d    = -8'(JUMP_V0);
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        StJump: begin
          x_d = x_move;
          if ((vy_q > 8'sd0) && (y_next >= $signed(13'(GROUND_Y)))) begin
            y_d     = 13'(GROUND_Y);
            vy_d    = '0;
            state_d = StCooldown;
            cnt_d   = '0;
          end else begin
            y_d  = y_next;
            vy_d = vy_q + 8'(GRAVITY);
          end
        end
        StCooldown: begin
          // >= so a limit that shrinks mid-cooldown still terminates promptly
          if (cnt_q >= cd_last) begin
            state_d = StChase;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        StDead: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    attack_d = (state_d == StJump);
    dead_d   = (state_d == StDead);
`ifdef BOSS_ENRAGE_EN
    enraged_d = (hp_d <= 7'(HP_MAX / 2)) && (state_d != StDead);
`else
    enraged_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || !game_active) begin
      state_q   <= StIdle;
      x_q       <= 12'(START_X);
      y_q       <= 13'(GROUND_Y);
      vy_q      <= '0;
      cnt_q     <= '0;
      hp_q      <= 7'(HP_MAX);
      iframe_q  <= '0;
      attack_q  <= 1'b0;
      dead_q    <= 1'b0;
      enraged_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      iframe_q  <= iframe_d;
      attack_q  <= attack_d;
      dead_q    <= dead_d;
      enraged_q <= enraged_d;
    end
  end

  assign boss_x        = x_q;
  assign boss_y        = y_q[11:0];
  assign boss_hp       = hp_q;
  assign attack_active = attack_q;
  assign boss_dead     = dead_q;
  assign enraged       = enraged_q;

endmodule

// File: tb/tb_boss_ctrl.sv
// Self-checking bench for boss_ctrl: directed scenarios plus random stimulus against a
// frame-level behavioural model.
module tb_boss_ctrl;

  logic        clk = 1'b0;
  logic        rst, game_active, frame_tick, hit_req;
  logic [11:0] player_x;
  logic [6:0]  hit_dmg;
  logic [11:0] boss_x, boss_y;
  logic [6:0]  boss_hp;
  logic        attack_active, boss_dead, enraged;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  boss_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .game_active  (game_active),
    .frame_tick   (frame_tick),
    .player_x     (player_x),
    .hit_req      (hit_req),
    .hit_dmg      (hit_dmg),
    .boss_x       (boss_x),
    .boss_y       (boss_y),
    .boss_hp      (boss_hp),
    .attack_active(attack_active),
    .boss_dead    (boss_dead),
    .enraged      (enraged)
  );

`ifdef BOSS_ENRAGE_EN
  localparam bit EnrEn = 1'b1;
`else
  localparam bit EnrEn = 1'b0;
`endif

  localparam int Idle = 0, Chase = 1, Windup = 2, Jump = 3, Cool = 4, Dead = 5;

  int m_st, m_x, m_y, m_vy, m_hp, m_if, m_cnt;
  bit m_enr;

  logic [33:0] dut_vec;
  assign dut_vec = {boss_x, boss_y, boss_hp, attack_active, boss_dead, enraged};

  function automatic logic [33:0] model_vec();
    return {12'(m_x), 12'(m_y), 7'(m_hp), m_st == Jump, m_st == Dead, m_enr};
  endfunction

  function automatic int toward(int x, int px, int step);
    int d = px - x;
    int r;
    if (d > step) d = step;
    if (d < -step) d = -step;
    r = x + d;
    if (r < 106) r = 106;
    if (r > 694) r = 694;
    return r;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_st = Idle; m_x = 600; m_y = 450; m_vy = 0; m_hp = 100; m_if = 0; m_cnt = 0; m_enr = 0;
  endtask

  task automatic model_step(bit r, bit ga, bit tick, bit hit, int dmg, int px);
    bit accept;
    int n_hp, n_if, speed, cd;
    if (r || !ga) begin
      model_reset();
      return;
    end
    accept = hit && m_if == 0 && m_hp > 0 && m_st != Idle;
    n_hp = m_hp;
    n_if = m_if;
    if (accept) begin
      n_hp = m_hp - ((dmg < m_hp) ? dmg : m_hp);
      n_if = 20;
    end else if (tick && m_if > 0) begin
      n_if = m_if - 1;
    end
    speed = m_enr ? 4 : 2;
    cd    = m_enr ? 30 : 60;
    if (m_hp == 0 && m_st != Idle) begin
      m_st = Dead;
    end else if (tick) begin
      case (m_st)
        Idle: m_st = Chase;
        Chase: begin
          m_x = toward(m_x, px, speed);
          if (iabs(px - m_x) <= 120) begin m_st = Windup; m_cnt = 0; end
        end
        Windup: begin
          m_cnt++;
          if (m_cnt >= 30) begin m_st = Jump; m_vy = -12; m_cnt = 0; end
        end
        Jump: begin
          m_x = toward(m_x, px, speed);
          if (m_vy > 0 && m_y + m_vy >= 450) begin
            m_y = 450; m_vy = 0; m_st = Cool; m_cnt = 0;
          end else begin
            m_y += m_vy; m_vy += 1;
          end
        end
        Cool: begin
          m_cnt++;
          if (m_cnt >= cd) begin m_st = Chase; m_cnt = 0; end
        end
        default: ;
      endcase
    end
    m_hp  = n_hp;
    m_if  = n_if;
    m_enr = EnrEn && m_hp <= 50 && m_st != Dead;
  endtask

  task automatic cycle(bit r, bit ga, bit tick, bit hit, int dmg, int px);
    rst = r; game_active = ga; frame_tick = tick; hit_req = hit;
    hit_dmg = 7'(dmg); player_x = 12'(px);
    model_step(r, ga, tick, hit, dmg, px);
    @(posedge clk);
    #1;
    rst = 1'b0; frame_tick = 1'b0; hit_req = 1'b0;
  endtask

  task automatic tick_frame(int px);
    cycle(0, 1, 1, 0, 0, px);
    cycle(0, 1, 0, 0, 0, px);
  endtask

  task automatic test_reset();
    cycle(1, 1, 0, 0, 0, 200);
    cycle(1, 1, 1, 0, 0, 200);
    n_checks++;
    if (dut_vec !== {12'd600, 12'd450, 7'd100, 3'b000}) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", dut_vec,
                         {12'd600, 12'd450, 7'd100, 3'b000});
    end
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_chase();
    for (int i = 1; i <= 11; i++) begin
      tick_frame(200);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL chase_model tick %0d: got %h expected %h", i, dut_vec, model_vec());
      end
      if (i == 1) begin
        n_checks++;
        if (boss_x !== 12'd600) begin
          n_fail++; $display("FAIL chase_first_tick: got %0d expected 600", boss_x);
        end
      end
    end
    n_checks++;
    if (boss_x !== 12'd580) begin
      n_fail++; $display("FAIL chase_x: got %0d expected 580", boss_x);
    end
  endtask

  task automatic test_jump();
    int peak, jt;
    tick_frame(560);
    n_checks++;
    if (boss_x !== 12'd578 || attack_active !== 1'b0) begin
      n_fail++; $display("FAIL windup_entry: got x=%0d atk=%b expected x=578 atk=0",
                         boss_x, attack_active);
    end
    for (int i = 1; i <= 30; i++) begin
      tick_frame(560);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL windup_model tick %0d: got %h expected %h", i, dut_vec, model_vec());
      end
      if (i == 29) begin
        n_checks++;
        if (attack_active !== 1'b0) begin
          n_fail++; $display("FAIL windup_early: got atk=%b expected 0", attack_active);
        end
      end
    end
    n_checks++;
    if (attack_active !== 1'b1 || boss_y !== 12'd450) begin
      n_fail++; $display("FAIL jump_start: got atk=%b y=%0d expected atk=1 y=450",
                         attack_active, boss_y);
    end
    peak = 450;
    jt   = 0;
    while (attack_active === 1'b1 && jt < 40) begin
      tick_frame(560);
      jt++;
      if (int'(boss_y) < peak) peak = int'(boss_y);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL jump_model tick %0d: got %h expected %h", jt, dut_vec, model_vec());
      end
    end
    n_checks++;
    if (jt != 25 || peak != 372 || boss_y !== 12'd450 || boss_x !== 12'd560) begin
      n_fail++; $display("FAIL jump_arc: got ticks=%0d peak=%0d y=%0d x=%0d expected 25/372/450/560",
                         jt, peak, boss_y, boss_x);
    end
    for (int i = 1; i <= 60; i++) begin
      tick_frame(300);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL cool_model tick %0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    n_checks++;
    if (boss_x !== 12'd560) begin
      n_fail++; $display("FAIL cool_hold: got %0d expected 560", boss_x);
    end
    tick_frame(300);
    n_checks++;
    if (boss_x !== 12'd558) begin
      n_fail++; $display("FAIL cool_exit: got %0d expected 558", boss_x);
    end
  endtask

  task automatic test_hits();
    cycle(0, 1, 0, 1, 30, 300);
    n_checks++;
    if (boss_hp !== 7'd70) begin
      n_fail++; $display("FAIL hit_first: got %0d expected 70", boss_hp);
    end
    for (int i = 0; i < 5; i++) tick_frame(300);
    cycle(0, 1, 0, 1, 30, 300);
    n_checks++;
    if (boss_hp !== 7'd70) begin
      n_fail++; $display("FAIL hit_iframe: got %0d expected 70", boss_hp);
    end
    for (int i = 0; i < 20; i++) begin
      tick_frame(300);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL hits_model: got %h expected %h", dut_vec, model_vec());
      end
    end
    cycle(0, 1, 0, 1, 80, 300);
    n_checks++;
    if (boss_hp !== 7'd0 || boss_dead !== 1'b0) begin
      n_fail++; $display("FAIL hit_kill: got hp=%0d dead=%b expected hp=0 dead=0", boss_hp, boss_dead);
    end
    cycle(0, 1, 0, 0, 0, 300);
    n_checks++;
    if (boss_dead !== 1'b1 || attack_active !== 1'b0) begin
      n_fail++; $display("FAIL dead_entry: got dead=%b atk=%b expected 1/0", boss_dead, attack_active);
    end
    for (int i = 0; i < 3; i++) tick_frame(300);
    n_checks++;
    if (boss_x !== 12'd508 || boss_dead !== 1'b1) begin
      n_fail++; $display("FAIL dead_frozen: got x=%0d dead=%b expected 508/1", boss_x, boss_dead);
    end
  endtask

  task automatic test_revive_iframes();
    cycle(0, 1, 0, 1, 10, 300);
    cycle(0, 0, 0, 0, 0, 300);
    n_checks++;
    if (dut_vec !== {12'd600, 12'd450, 7'd100, 3'b000}) begin
      n_fail++; $display("FAIL revive: got %h expected %h", dut_vec, {12'd600, 12'd450, 7'd100, 3'b000});
    end
    cycle(0, 1, 1, 0, 0, 300);
    cycle(0, 1, 1, 1, 20, 300);
    n_checks++;
    if (boss_hp !== 7'd80 || boss_x !== 12'd598) begin
      n_fail++; $display("FAIL hit_on_tick: got hp=%0d x=%0d expected 80/598", boss_hp, boss_x);
    end
    for (int i = 0; i < 19; i++) tick_frame(300);
    cycle(0, 1, 0, 1, 5, 300);
    n_checks++;
    if (boss_hp !== 7'd80) begin
      n_fail++; $display("FAIL iframe_last: got %0d expected 80", boss_hp);
    end
    tick_frame(300);
    cycle(0, 1, 0, 1, 0, 300);
    cycle(0, 1, 0, 1, 5, 300);
    n_checks++;
    if (boss_hp !== 7'd80 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL zero_dmg_iframe: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_enrage();
    cycle(0, 0, 0, 0, 0, 100);
    cycle(0, 1, 1, 0, 0, 100);
    cycle(0, 1, 0, 1, 50, 100);
    n_checks++;
    if (boss_hp !== 7'd50 || enraged !== EnrEn) begin
      n_fail++; $display("FAIL enrage_flag: got hp=%0d enr=%b expected 50/%b", boss_hp, enraged, EnrEn);
    end
    tick_frame(100);
    n_checks++;
    if (boss_x !== (EnrEn ? 12'd596 : 12'd598)) begin
      n_fail++; $display("FAIL enrage_step: got %0d expected %0d", boss_x, EnrEn ? 596 : 598);
    end
  endtask

  task automatic test_random();
    int px = 400;
    for (int i = 0; i < 4000; i++) begin
      bit r    = ($urandom_range(0, 999) == 0);
      bit ga   = ($urandom_range(0, 599) != 0);
      bit tick = ($urandom_range(0, 3) == 0);
      bit hit  = ($urandom_range(0, 39) == 0);
      int dmg  = int'($urandom_range(0, 12));
      if ($urandom_range(0, 63) == 0) px = int'($urandom_range(0, 900));
      cycle(r, ga, tick, hit, dmg, px);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; game_active = 1'b1; frame_tick = 1'b0; hit_req = 1'b0;
    hit_dmg = '0; player_x = 12'd200;
    model_reset();
    test_reset();
    test_chase();
    test_jump();
    test_hits();
    test_revive_iframes();
    test_enrage();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
